pixel_writer: RTL and testbench

Downstream consumer of the obstacle processor's pixel stream. It accepts `xpos`/`ypos`/`color`/`plot` strobes, which arrive without backpressure, and buffers them in a small FIFO. It converts each coordinate to a linear framebuffer address and drains the FIFO through a valid/ready write port into the 160x120, 3-bit framebuffer RAM. It also performs full-screen clears with a background colour, automatically after reset and on request.

---
 rtl/vga_pkg.sv | 28 ++
 rtl/plot_fifo.sv | 50 +++++
 rtl/pixel_writer.sv | 137 +++++++++++++
 tb/tb_pixel_writer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared screen geometry, framebuffer sizing and pixel-writer state encodings.
// Also holds the helper that maps a coordinate to a linear framebuffer address.
package vga_pkg;
  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int FB_ADDR_W = 15;
  localparam int FB_WORDS  = 19200;
  localparam int COLOR_W   = 3;
  localparam int PIX_W     = 8 + 7 + COLOR_W;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  typedef struct packed {
    logic [7:0]         x;
    logic [6:0]         y;
    logic [COLOR_W-1:0] c;
  } pixel_t;

  // y*160 + x built from shifts so no multiplier is needed
  function automatic logic [FB_ADDR_W-1:0] pix_addr(input logic [7:0] x, input logic [6:0] y);
    logic [FB_ADDR_W-1:0] w_y;
    w_y = {8'd0, y};
    return (w_y << 7) + (w_y << 5) + {7'd0, x};
  endfunction
endpackage

// File: rtl/plot_fifo.sv
// Synchronous FIFO with registered full/empty flags and wrap-bit pointers.
// Writes while full and reads while empty are ignored; no bypass path.
module plot_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 18
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_wr,
  input  logic [W-1:0] i_wdata,
  input  logic         i_rd,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr, r_rptr;
  logic         r_full, r_empty;
  logic [AW:0]  w_wptr_n, w_rptr_n;
  logic         w_wr, w_rd;

  assign w_wr     = i_wr && !r_full;
  assign w_rd     = i_rd && !r_empty;
  assign w_wptr_n = r_wptr + {{AW{1'b0}}, w_wr};
  assign w_rptr_n = r_rptr + {{AW{1'b0}}, w_rd};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_wptr  <= w_wptr_n;
      r_rptr  <= w_rptr_n;
      r_empty <= (w_wptr_n == w_rptr_n);
      r_full  <= (w_wptr_n == {~w_rptr_n[AW], w_rptr_n[AW-1:0]});
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr[AW-1:0]];
  assign o_full  = r_full;
  assign o_empty = r_empty;
endmodule

// File: rtl/pixel_writer.sv
// Buffers plot strobes, converts them to framebuffer addresses and drains them
// through a valid/ready write port; also sweeps the screen with a background colour.
module pixel_writer
  import vga_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int WIDTH  = SCREEN_W,
  parameter int HEIGHT = SCREEN_H
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           xpos,
  input  logic [6:0]           ypos,
  input  logic [COLOR_W-1:0]   color,
  input  logic                 plot,
  input  logic                 clear,
  input  logic [COLOR_W-1:0]   bg_color,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [COLOR_W-1:0]   fb_data,
  output logic                 fb_we,
  input  logic                 fb_ready,
  output logic                 busy,
  output logic                 overflow
);
  localparam logic [FB_ADDR_W-1:0] LP_WORDS = FB_ADDR_W'(FB_WORDS);

  state_t                 r_state, w_state_n;
  logic [FB_ADDR_W-1:0]   r_cnt, w_cnt_n, w_sweep;
  logic                   r_pend, w_pend_n;
  logic                   r_we, w_we_n;
  logic [FB_ADDR_W-1:0]   r_addr, w_addr_n;
  logic [COLOR_W-1:0]     r_data, w_data_n;
  logic                   r_ovf;

  logic                   w_in_range, w_enq, w_drop, w_deq, w_free;
  logic                   w_full, w_empty;
  logic [PIX_W-1:0]       w_rdata;
  pixel_t                 w_head;
  logic [FB_ADDR_W-1:0]   w_head_addr;

  // Input qualification: out-of-range pixels vanish, in-range ones hitting a full FIFO are dropped
  assign w_in_range = (32'(xpos) < WIDTH) && (32'(ypos) < HEIGHT);
  assign w_enq      = plot && w_in_range && !w_full;
  assign w_drop     = plot && w_in_range && w_full;

  plot_fifo #(.DEPTH(DEPTH), .W(PIX_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_wr    (w_enq),
    .i_wdata ({xpos, ypos, color}),
    .i_rd    (w_deq),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head      = w_rdata;
  assign w_head_addr = pix_addr(w_head.x, w_head.y);
  assign w_free      = !r_we || fb_ready;

  // Output register reload / FSM next state
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_pend_n  = r_pend;
    w_we_n    = r_we;
    w_addr_n  = r_addr;
    w_data_n  = r_data;
    w_deq     = 1'b0;
    w_sweep   = clear ? '0 : r_cnt;
    unique case (r_state)
      S_RUN: begin
        if (r_pend || clear) begin
          if (w_free) begin
            w_state_n = S_CLEAR;
            w_pend_n  = 1'b0;
            w_we_n    = 1'b1;
            w_addr_n  = '0;
            w_data_n  = bg_color;
            w_cnt_n   = FB_ADDR_W'(1);
          end else begin
            w_pend_n = 1'b1;
          end
        end else if (w_free) begin
          w_deq    = !w_empty;
          w_we_n   = !w_empty;
          w_addr_n = w_head_addr;
          w_data_n = w_head.c;
        end
      end
      default: begin
        // r_cnt is the next sweep address to load; reaching FB_WORDS means the last one is in flight
        if (!w_free) begin
          w_cnt_n = w_sweep;
        end else if (w_sweep < LP_WORDS) begin
          w_we_n   = 1'b1;
          w_addr_n = w_sweep;
          w_data_n = bg_color;
          w_cnt_n  = w_sweep + FB_ADDR_W'(1);
        end else begin
          w_state_n = S_RUN;
          w_deq     = !w_empty;
          w_we_n    = !w_empty;
          w_addr_n  = w_head_addr;
          w_data_n  = w_head.c;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
      r_pend  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_pend  <= w_pend_n;
      r_we    <= w_we_n;
      r_addr  <= w_addr_n;
      r_data  <= w_data_n;
      if (w_drop)     r_ovf <= 1'b1;
      else if (clear) r_ovf <= 1'b0;
    end
  end

  assign fb_addr  = r_addr;
  assign fb_data  = r_data;
  assign fb_we    = r_we;
  assign overflow = r_ovf;
  assign busy     = (r_state == S_CLEAR) || !w_empty || r_we;
endmodule

// File: tb/tb_pixel_writer.sv
// Self-checking bench for pixel_writer: directed scenarios plus randomized plot traffic
// compared against an ordered list of expected framebuffer writes.
module tb_pixel_writer;
  localparam int DEPTH  = 8;
  localparam int NWORDS = 160 * 120;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  xpos;
  logic [6:0]  ypos;
  logic [2:0]  color;
  logic        plot;
  logic        clear;
  logic [2:0]  bg_color;
  logic [14:0] fb_addr;
  logic [2:0]  fb_data;
  logic        fb_we;
  logic        fb_ready;
  logic        busy;
  logic        overflow;

  int errors = 0;
  int checks = 0;
  logic [17:0] obs_q[$];

  always #5 clk = ~clk;

  pixel_writer #(.DEPTH(DEPTH), .WIDTH(160), .HEIGHT(120)) dut (
    .clk      (clk),
    .reset    (reset),
    .xpos     (xpos),
    .ypos     (ypos),
    .color    (color),
    .plot     (plot),
    .clear    (clear),
    .bg_color (bg_color),
    .fb_addr  (fb_addr),
    .fb_data  (fb_data),
    .fb_we    (fb_we),
    .fb_ready (fb_ready),
    .busy     (busy),
    .overflow (overflow)
  );

  // Every write accepted by the RAM, in order
  always @(negedge clk)
    if (reset === 1'b1 && fb_we === 1'b1 && fb_ready === 1'b1)
      obs_q.push_back({fb_addr, fb_data});

  function automatic logic [17:0] pix(input int x, input int y, input int c);
    int a;
    a = y * 160 + x;
    return {a[14:0], c[2:0]};
  endfunction

  // Number of entries from index start that differ from a full in-order sweep with colour bg
  function automatic int sweep_errs(input int start, input logic [2:0] bg);
    int n;
    n = 0;
    for (int i = 0; i < NWORDS; i++) begin
      if (start + i >= obs_q.size()) n++;
      else if (obs_q[start + i] !== {i[14:0], bg}) n++;
    end
    return n;
  endfunction

  task automatic test_reset();
    reset = 1'b0; plot = 1'b0; clear = 1'b0; fb_ready = 1'b0;
    bg_color = 3'd1; xpos = '0; ypos = '0; color = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (fb_we !== 1'b0 || fb_addr !== 15'd0 || fb_data !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs: we=%b addr=%0d data=%0d, want 0/0/0", fb_we, fb_addr, fb_data);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_overflow: got %b want 0", overflow);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_busy: got %b want 1", busy);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (fb_we !== 1'b1 || fb_addr !== 15'd0) begin
      errors++;
      $display("FAIL first_clear_write: we=%b addr=%0d, want 1/0", fb_we, fb_addr);
    end
  endtask

  task automatic test_clear_sweep();
    int last_idx, drop_idx, n;
    last_idx = -1; drop_idx = -1;
    obs_q.delete();
    @(posedge clk); #1 fb_ready = 1'b1;
    for (int i = 0; i < 20500; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin drop_idx = i; break; end
      if (fb_we === 1'b1 && fb_ready === 1'b1 && fb_addr === 15'd19199) last_idx = i;
    end
    checks++;
    if (drop_idx < 0 || drop_idx != last_idx + 1) begin
      errors++;
      $display("FAIL clear_busy_drop: busy fell at cycle %0d, last write at %0d", drop_idx, last_idx);
    end
    checks++;
    if (obs_q.size() != NWORDS) begin
      errors++;
      $display("FAIL clear_count: got %0d writes want %0d", obs_q.size(), NWORDS);
    end
    n = sweep_errs(0, 3'd1);
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL clear_content: %0d bad entries want 0", n);
    end
    checks++;
    if (fb_we !== 1'b0) begin
      errors++;
      $display("FAIL clear_idle_we: got %b want 0", fb_we);
    end
  endtask

  task automatic test_plot_latency();
    obs_q.delete();
    @(posedge clk); #1 xpos = 8'd5; ypos = 7'd2; color = 3'd4; plot = 1'b1;
    @(posedge clk); #1 plot = 1'b0;
    @(negedge clk);
    checks++;
    if (fb_we !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: we=%b one edge after plot, want 0", fb_we);
    end
    @(negedge clk);
    checks++;
    if (fb_we !== 1'b1 || fb_addr !== 15'd325 || fb_data !== 3'd4) begin
      errors++;
      $display("FAIL latency_write: we=%b addr=%0d data=%0d, want 1/325/4", fb_we, fb_addr, fb_data);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_out_of_range();
    int xs[3] = '{160, 10, 255};
    int ys[3] = '{10, 120, 127};
    obs_q.delete();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 xpos = 8'(xs[i]); ypos = 7'(ys[i]); color = 3'd7; plot = 1'b1;
    end
    @(posedge clk); #1 plot = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (obs_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL range_discard: %0d writes busy=%b, want 0 writes busy 0", obs_q.size(), busy);
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL range_overflow: got %b want 0", overflow);
    end
    @(posedge clk); #1 xpos = 8'd159; ypos = 7'd119; color = 3'd6; plot = 1'b1;
    @(posedge clk); #1 plot = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== pix(159, 119, 6)) begin
      errors++;
      $display("FAIL range_corner: %0d writes first=%h, want 1 write %h", obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0] : 18'h0, pix(159, 119, 6));
    end
  endtask

  task automatic test_random();
    logic [17:0] exp_q[$];
    int x, y, c, bad;
    obs_q.delete();
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      fb_ready = ($urandom_range(0, 3) != 0);
      x = $urandom_range(0, 170);
      y = $urandom_range(0, 127);
      c = $urandom_range(0, 7);
      plot = ($urandom_range(0, 2) == 0);
      if (x < 160 && y < 120) begin
        if (exp_q.size() - obs_q.size() >= DEPTH) plot = 1'b0;
        if (plot) exp_q.push_back(pix(x, y, c));
      end
      xpos = 8'(x); ypos = 7'(y); color = 3'(c);
    end
    @(posedge clk); #1 plot = 1'b0; fb_ready = 1'b1;
    repeat (DEPTH + 8) @(negedge clk);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_count: got %0d writes want %0d", obs_q.size(), exp_q.size());
    end
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL random_content: %0d mismatched writes want 0", bad);
    end
    checks++;
    if (overflow !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL random_idle: overflow=%b busy=%b want 0/0", overflow, busy);
    end
  endtask

  task automatic test_overflow();
    int bad;
    obs_q.delete();
    @(posedge clk); #1 fb_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      xpos = 8'(10 + i); ypos = 7'(20 + i); color = 3'(i); plot = 1'b1;
      @(posedge clk); #1;
    end
    plot = 1'b0;
    @(negedge clk);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set: got %b want 1", overflow);
    end
    checks++;
    if (fb_we !== 1'b1 || {fb_addr, fb_data} !== pix(10, 20, 0)) begin
      errors++;
      $display("FAIL overflow_stall: we=%b word=%h want 1/%h", fb_we, {fb_addr, fb_data}, pix(10, 20, 0));
    end
    @(posedge clk); #1 fb_ready = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if (obs_q.size() != 9) begin
      errors++;
      $display("FAIL overflow_count: got %0d writes want 9", obs_q.size());
    end
    bad = 0;
    for (int i = 0; i < 9; i++)
      if (i >= obs_q.size() || obs_q[i] !== pix(10 + i, 20 + i, i)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL overflow_order: %0d mismatched writes want 0", bad);
    end
  endtask

  task automatic test_clear_stalled();
    int n, drop_idx;
    drop_idx = -1;
    obs_q.delete();
    @(posedge clk); #1 fb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      xpos = 8'(30 + i); ypos = 7'(40 + i); color = 3'(2 + i); plot = 1'b1;
      @(posedge clk); #1;
    end
    plot = 1'b0; bg_color = 3'd5; clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL clear_ovf_reset: got %b want 0", overflow);
    end
    checks++;
    if (fb_we !== 1'b1 || {fb_addr, fb_data} !== pix(30, 40, 2)) begin
      errors++;
      $display("FAIL clear_stalled_hold: we=%b word=%h want 1/%h", fb_we, {fb_addr, fb_data}, pix(30, 40, 2));
    end
    @(posedge clk); #1 fb_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1 xpos = 8'd100; ypos = 7'd100; color = 3'd7; plot = 1'b1;
    @(posedge clk); #1 plot = 1'b0;
    for (int i = 0; i < 20500; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin drop_idx = i; break; end
    end
    checks++;
    if (drop_idx < 0) begin
      errors++;
      $display("FAIL clear_stalled_timeout: busy never fell");
    end
    checks++;
    if (obs_q.size() != NWORDS + 4) begin
      errors++;
      $display("FAIL clear_stalled_count: got %0d writes want %0d", obs_q.size(), NWORDS + 4);
    end
    checks++;
    if (obs_q.size() < 1 || obs_q[0] !== pix(30, 40, 2)) begin
      errors++;
      $display("FAIL clear_stalled_first: first write not the stalled pixel %h", pix(30, 40, 2));
    end
    n = sweep_errs(1, 3'd5);
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL clear_stalled_sweep: %0d bad entries want 0", n);
    end
    checks++;
    if (obs_q.size() != NWORDS + 4 || obs_q[NWORDS + 1] !== pix(31, 41, 3) ||
        obs_q[NWORDS + 2] !== pix(32, 42, 4) || obs_q[NWORDS + 3] !== pix(100, 100, 7)) begin
      errors++;
      $display("FAIL clear_stalled_tail: queued pixels not written after sweep, got %0d writes", obs_q.size());
    end
  endtask

  task automatic test_reset_mid_clear();
    int found, drop_idx, n;
    found = 0; drop_idx = -1;
    @(posedge clk); #1 bg_color = 3'd2; clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0; xpos = 8'd7; ypos = 7'd7; color = 3'd3; plot = 1'b1;
    @(posedge clk); #1 plot = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (fb_we === 1'b1 && fb_ready === 1'b1 && fb_addr === 15'd500) begin found = 1; break; end
    end
    checks++;
    if (found == 0) begin
      errors++;
      $display("FAIL midclear_reach500: address 500 never written");
    end
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    checks++;
    if (fb_we !== 1'b0 || fb_addr !== 15'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midclear_reset: we=%b addr=%0d busy=%b want 0/0/1", fb_we, fb_addr, busy);
    end
    obs_q.delete();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (fb_we !== 1'b1 || fb_addr !== 15'd0) begin
      errors++;
      $display("FAIL midclear_restart: we=%b addr=%0d want 1/0", fb_we, fb_addr);
    end
    for (int i = 0; i < 20500; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin drop_idx = i; break; end
    end
    checks++;
    if (drop_idx < 0 || obs_q.size() != NWORDS) begin
      errors++;
      $display("FAIL midclear_count: %0d writes (busy fell at %0d), want %0d and no pixel",
               obs_q.size(), drop_idx, NWORDS);
    end
    n = sweep_errs(0, 3'd2);
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL midclear_sweep: %0d bad entries want 0", n);
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clear_sweep();
    test_plot_latency();
    test_out_of_range();
    test_random();
    test_overflow();
    test_clear_stalled();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
